// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared types and helpers for the sequential power-of-two MLP:
//               weight-code layout, FSM state encodings and the saturating
//               accumulator add.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

  // Weight code layout: {zero, sign, shift[2:0]}
  localparam int c_wc_w         = 5;
  localparam int c_wc_zero_bit  = 4;
  localparam int c_wc_sign_bit  = 3;
  localparam int c_wc_shift_lsb = 0;
  localparam int c_wc_shift_w   = 3;

  typedef struct packed {
    logic                    zero;
    logic                    sign;
    logic [c_wc_shift_w-1:0] shift;
  } wcode_t;

  // FSM state encodings
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_l0     = 3'd1;
  localparam logic [2:0] c_st_l1     = 3'd2;
  localparam logic [2:0] c_st_argmax = 3'd3;
  localparam logic [2:0] c_st_done   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = c_st_idle,
    ST_L0     = c_st_l0,
    ST_L1     = c_st_l1,
    ST_ARGMAX = c_st_argmax,
    ST_DONE   = c_st_done
  } mlp_state_e;

  // Add two sign-extended values and clamp the result to the signed range of
  // a w-bit accumulator, so an overflowing sum sticks at the rail.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pow2_term.sv
`default_nettype none
// ============================================================================
// Module      : pow2_term
// Description : Combinational weight-term generator. Turns an unsigned operand
//               and a power-of-two weight code into a signed ACC_W term:
//               0 when the zero flag is set, else +/-(x << shift).
// Revision    : 1.0 - initial release
// ============================================================================
module pow2_term
  import mlp_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int ACC_W = 16
) (
  input  logic [X_W-1:0]          i_x,
  input  logic [c_wc_w-1:0]       i_code,
  output logic signed [ACC_W-1:0] o_term
);

  wcode_t           w_code;
  logic [ACC_W-1:0] w_mag;

  assign w_code = wcode_t'(i_code);
  assign w_mag  = ACC_W'(i_x) << w_code.shift;

  // Select zero, the shifted magnitude, or its two's-complement negation
  always_comb begin
    o_term = '0;
    if (!w_code.zero) begin
      o_term = w_code.sign ? -w_mag : w_mag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_pow2_mlp.sv
`default_nettype none
// ============================================================================
// Module      : seq_pow2_mlp
// Description : Sequential two-layer MLP with power-of-two weights. One shared
//               saturating adder-accumulator computes one weight term per
//               cycle: hidden layer (ReLU, clamped to ACT_W), output layer
//               (ReLU), then a serial argmax with lowest-index tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pow2_mlp
  import mlp_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int IN_W  = 4,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int ACT_W = 8,
  parameter int ACC_W = 16,
  parameter logic [N_HID*N_IN*c_wc_w-1:0]  W0 = '0,
  parameter logic [N_OUT*N_HID*c_wc_w-1:0] W1 = '0,
  parameter logic [N_HID*ACC_W-1:0]        B0 = '0,
  parameter logic [N_OUT*ACC_W-1:0]        B1 = '0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clr,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_IN*IN_W-1:0]                          in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]  out_class,
  output logic [ACC_W-1:0]                              out_score,
  output logic                                          busy
);

  localparam int c_oc_w  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int c_x_w   = (IN_W > ACT_W) ? IN_W : ACT_W;
  localparam int c_max_n = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                          : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int c_cnt_w = $clog2(c_max_n + 1);
  localparam logic signed [ACC_W-1:0] c_act_max = ACC_W'((1 << ACT_W) - 1);

  logic [2:0]               r_state;
  logic [c_cnt_w-1:0]       r_row;
  logic [c_cnt_w-1:0]       r_col;
  logic [N_IN*IN_W-1:0]     r_feat;
  logic [N_HID*ACT_W-1:0]   r_hid;
  logic [N_OUT*ACC_W-1:0]   r_score;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_best_score;
  logic [c_oc_w-1:0]        r_best_class;

  logic [c_x_w-1:0]         w_x;
  logic [c_wc_w-1:0]        w_code;
  logic signed [ACC_W-1:0]  w_bias;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [63:0]       w_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [ACT_W-1:0]         w_hid_val;
  logic signed [ACC_W-1:0]  w_score_val;
  logic signed [ACC_W-1:0]  w_cand;
  logic                     w_l0_last_col;
  logic                     w_l1_last_col;
  logic                     w_l0_last_row;
  logic                     w_l1_last_row;
  logic                     w_arg_last;

  assign in_ready  = (r_state == c_st_idle);
  assign busy      = (r_state != c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign out_class = r_best_class;
  assign out_score = r_best_score;

  assign w_l0_last_col = (r_col == c_cnt_w'(N_IN - 1));
  assign w_l1_last_col = (r_col == c_cnt_w'(N_HID - 1));
  assign w_l0_last_row = (r_row == c_cnt_w'(N_HID - 1));
  assign w_l1_last_row = (r_row == c_cnt_w'(N_OUT - 1));
  assign w_arg_last    = (r_row == c_cnt_w'(N_OUT - 1));

  // Route the current layer's operand, weight code and bias to the shared adder
  always_comb begin
    w_x    = '0;
    w_code = '0;
    w_bias = '0;
    if (r_state == c_st_l1) begin
      w_x    = c_x_w'(r_hid[int'(r_col)*ACT_W +: ACT_W]);
      w_code = W1[(int'(r_row)*N_HID + int'(r_col))*c_wc_w +: c_wc_w];
      w_bias = B1[int'(r_row)*ACC_W +: ACC_W];
    end else begin
      w_x    = c_x_w'(r_feat[int'(r_col)*IN_W +: IN_W]);
      w_code = W0[(int'(r_row)*N_IN + int'(r_col))*c_wc_w +: c_wc_w];
      w_bias = B0[int'(r_row)*ACC_W +: ACC_W];
    end
  end

  pow2_term #(
    .X_W   (c_x_w),
    .ACC_W (ACC_W)
  ) u_term (
    .i_x    (w_x),
    .i_code (w_code),
    .o_term (w_term)
  );

  // The single adder-accumulator: first term of a neuron starts from its bias
  always_comb begin
    w_base      = (r_col == '0) ? w_bias : r_acc;
    w_sum       = sat_add(64'(w_base), 64'(w_term), ACC_W);
    w_acc_next  = w_sum[ACC_W-1:0];
    w_hid_val   = w_acc_next[ACT_W-1:0];
    if (w_acc_next < 0) begin
      w_hid_val = '0;
    end else if (w_acc_next > c_act_max) begin
      w_hid_val = '1;
    end
    w_score_val = (w_acc_next < 0) ? '0 : w_acc_next;
    w_cand      = r_score[int'(r_row)*ACC_W +: ACC_W];
  end

  // Sequencing: state and the neuron-major row/column term counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_row   <= '0;
      r_col   <= '0;
    end else if (clr) begin
      r_state <= c_st_idle;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_row   <= '0;
            r_col   <= '0;
            r_state <= c_st_l0;
          end
        end
        c_st_l0: begin
          if (w_l0_last_col) begin
            r_col <= '0;
            if (w_l0_last_row) begin
              r_row   <= '0;
              r_state <= c_st_l1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        c_st_l1: begin
          if (w_l1_last_col) begin
            r_col <= '0;
            if (w_l1_last_row) begin
              r_row   <= '0;
              r_state <= c_st_argmax;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        c_st_argmax: begin
          if (w_arg_last) begin
            r_row   <= '0;
            r_state <= c_st_done;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Datapath storage: captured features, accumulator, activations and scores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat  <= '0;
      r_acc   <= '0;
      r_hid   <= '0;
      r_score <= '0;
    end else if (clr) begin
      r_acc   <= '0;
      r_hid   <= '0;
      r_score <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_feat <= in_data;
          end
        end
        c_st_l0: begin
          r_acc <= w_acc_next;
          if (w_l0_last_col) begin
            r_hid[int'(r_row)*ACT_W +: ACT_W] <= w_hid_val;
          end
        end
        c_st_l1: begin
          r_acc <= w_acc_next;
          if (w_l1_last_col) begin
            r_score[int'(r_row)*ACC_W +: ACC_W] <= w_score_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Serial argmax: replace only on strictly greater so ties keep the lower index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_score <= '0;
      r_best_class <= '0;
    end else if (!clr && (r_state == c_st_argmax)) begin
      if ((r_row == '0) || (w_cand > r_best_score)) begin
        r_best_score <= w_cand;
        r_best_class <= r_row[c_oc_w-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_pow2_mlp.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pow2_mlp
// Description : Self-checking bench for seq_pow2_mlp. Five weight configs run
//               side by side on shared stimulus; a transaction-level model
//               predicts handshakes, latency and the argmax result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pow2_mlp;

  localparam int NI  = 6;
  localparam int IW  = 4;
  localparam int NH  = 3;
  localparam int NO  = 3;
  localparam int AW  = 8;
  localparam int CW  = 16;
  localparam int NC  = 5;
  localparam int LAT = NH*NI + NO*NH + NO;

  // Config 0: T1. 1: T1 + B1 class2=5. 2: W0 all +shift3. 3: W0 all -1.
  // Config 4: mixed codes with large biases that drive the accumulator rails.
  function automatic logic [NH*NI*5-1:0] cfg_w0(input int c);
    logic [NH*NI*5-1:0] v;
    v = '0;
    case (c)
      2: v = {(NH*NI){5'b00011}};
      3: v = {(NH*NI){5'b01000}};
      4: for (int i = 0; i < NH*NI; i++) v[i*5 +: 5] = 5'((i*7 + 3) % 32);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [NO*NH*5-1:0] cfg_w1(input int c);
    logic [NO*NH*5-1:0] v;
    v = '0;
    for (int i = 0; i < NO*NH; i++) begin
      if (c == 4) v[i*5 +: 5] = 5'((i*13 + 6) % 32);
      else        v[i*5 +: 5] = ((i / NH) == (i % NH)) ? 5'b00000 : 5'b10000;
    end
    return v;
  endfunction

  function automatic logic [NH*CW-1:0] cfg_b0(input int c);
    return (c == 4) ? {16'hFFEC, 16'd10, 16'd3} : '0;
  endfunction

  function automatic logic [NO*CW-1:0] cfg_b1(input int c);
    logic [NO*CW-1:0] v;
    case (c)
      1:       v = {16'd5, 16'd0, 16'd0};
      4:       v = {16'h8300, 16'd32000, 16'd100};
      default: v = '0;
    endcase
    return v;
  endfunction

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int term(input logic [4:0] code, input int x);
    int m;
    if (code[4]) return 0;
    m = x * (2 ** int'(code[2:0]));
    return code[3] ? -m : m;
  endfunction

  function automatic void ref_model(input int c, input logic [NI*IW-1:0] d,
                                    output int cls, output int sc);
    logic [NH*NI*5-1:0] w0;
    logic [NO*NH*5-1:0] w1;
    logic [NH*CW-1:0]   b0;
    logic [NO*CW-1:0]   b1;
    int h [NH];
    int s [NO];
    int acc;
    w0 = cfg_w0(c); w1 = cfg_w1(c); b0 = cfg_b0(c); b1 = cfg_b1(c);
    for (int j = 0; j < NH; j++) begin
      acc = int'($signed(b0[j*CW +: CW]));
      for (int i = 0; i < NI; i++)
        acc = sat16(acc + term(w0[(j*NI + i)*5 +: 5], int'(d[i*IW +: IW])));
      h[j] = (acc < 0) ? 0 : ((acc > (2**AW - 1)) ? (2**AW - 1) : acc);
    end
    for (int k = 0; k < NO; k++) begin
      acc = int'($signed(b1[k*CW +: CW]));
      for (int j = 0; j < NH; j++)
        acc = sat16(acc + term(w1[(k*NH + j)*5 +: 5], h[j]));
      s[k] = (acc < 0) ? 0 : acc;
    end
    cls = 0; sc = s[0];
    for (int k = 1; k < NO; k++) if (s[k] > sc) begin cls = k; sc = s[k]; end
  endfunction

  // ---------------- DUTs ----------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [NI*IW-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             ir [NC];
  logic             ov [NC];
  logic             bz [NC];
  logic [1:0]       oc [NC];
  logic [CW-1:0]    os [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    seq_pow2_mlp #(
      .N_IN(NI), .IN_W(IW), .N_HID(NH), .N_OUT(NO), .ACT_W(AW), .ACC_W(CW),
      .W0(cfg_w0(g)), .W1(cfg_w1(g)), .B0(cfg_b0(g)), .B1(cfg_b1(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_class(oc[g]), .out_score(os[g]), .busy(bz[g])
    );
  end

  // ---------------- checking infrastructure ---------------------------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: idle/computing/result-pending plus results
  bit m_idle = 1'b1;
  bit m_valid = 1'b0;
  int m_cnt = 0;
  int m_cls [NC];
  int m_sc  [NC];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_idle = 1'b1; m_valid = 1'b0;
      end else if (clr) begin
        m_idle = 1'b1; m_valid = 1'b0;
      end else if (m_idle) begin
        if (in_valid) begin
          m_idle = 1'b0; m_cnt = 0;
          for (int c = 0; c < NC; c++) ref_model(c, in_data, m_cls[c], m_sc[c]);
        end
      end else if (!m_valid) begin
        m_cnt++;
        if (m_cnt == LAT) m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0; m_idle = 1'b1;
      end
    end
  end

  // Compare every DUT against the model on each falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < NC; c++) begin
          chk($sformatf("cfg%0d in_ready", c),  32'(ir[c]), 32'(m_idle));
          chk($sformatf("cfg%0d busy", c),      32'(bz[c]), 32'(!m_idle));
          chk($sformatf("cfg%0d out_valid", c), 32'(ov[c]), 32'(m_valid));
          if (m_valid) begin
            chk($sformatf("cfg%0d out_class", c), 32'(oc[c]), 32'(m_cls[c]));
            chk($sformatf("cfg%0d out_score", c), 32'(os[c]), 32'(m_sc[c]));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NI*IW-1:0] d);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (ov[0] !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("out_valid timeout", 32'(ov[0]), 32'd1);
  endtask

  task automatic expect_no_valid(input string nm, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ov[0] === 1'b1) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  localparam logic [NI*IW-1:0] ALL15 = {NI{4'hF}};
  int exp_cls [4] = '{0, 2, 0, 0};
  int exp_sc  [4] = '{90, 95, 255, 0};

  initial begin
    int cyc;
    int pc;
    int ps;
    // Pin the model to hand-computed results for the all-15 vector
    for (int c = 0; c < 4; c++) begin
      ref_model(c, ALL15, pc, ps);
      chk($sformatf("model cfg%0d class", c), 32'(pc), 32'(exp_cls[c]));
      chk($sformatf("model cfg%0d score", c), 32'(ps), 32'(exp_sc[c]));
    end

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("reset cfg%0d in_ready", c),  32'(ir[c]), 32'd1);
      chk($sformatf("reset cfg%0d out_valid", c), 32'(ov[c]), 32'd0);
      chk($sformatf("reset cfg%0d busy", c),      32'(bz[c]), 32'd0);
      chk($sformatf("reset cfg%0d out_class", c), 32'(oc[c]), 32'd0);
      chk($sformatf("reset cfg%0d out_score", c), 32'(os[c]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Basic vector: latency and literal results
    send(ALL15);
    wait_valid(cyc);
    chk("latency", 32'(cyc), 32'd30);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("all15 cfg%0d class", c), 32'(oc[c]), 32'(exp_cls[c]));
      chk($sformatf("all15 cfg%0d score", c), 32'(os[c]), 32'(exp_sc[c]));
    end
    tick();
    chk("in_ready after handshake", 32'(ir[0]), 32'd1);

    // Back-pressure hold with an ignored in_valid pulse
    out_ready = 1'b0;
    send(ALL15);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); in_data = '0;
      tick();
      chk("hold out_valid", 32'(ov[1]), 32'd1);
      chk("hold in_ready",  32'(ir[1]), 32'd0);
      chk("hold class",     32'(oc[1]), 32'd2);
      chk("hold score",     32'(os[1]), 32'd95);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
    tick();
    chk("no accept on release cycle", 32'(bz[0]), 32'd0);
    tick();
    chk("accept after release", 32'(bz[0]), 32'd1);
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("zero vec cfg1 class", 32'(oc[1]), 32'd2);
    chk("zero vec cfg1 score", 32'(os[1]), 32'd5);
    tick();

    // Asynchronous reset mid-computation
    send(ALL15);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready",  32'(ir[0]), 32'd1);
    chk("async rst out_score", 32'(os[0]), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("in_ready after rst release", 32'(ir[0]), 32'd1);
    expect_no_valid("no out_valid after reset", 40);
    send(ALL15);
    wait_valid(cyc);
    chk("post-reset latency", 32'(cyc), 32'd30);
    chk("post-reset score",   32'(os[0]), 32'd90);
    tick();

    // Synchronous clear mid-computation
    send(24'h5A3C96);
    for (int i = 0; i < 19; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("in_ready after clr", 32'(ir[0]), 32'd1);
    chk("busy after clr",     32'(bz[0]), 32'd0);
    expect_no_valid("no out_valid after clr", 40);
    send(ALL15);
    wait_valid(cyc);
    chk("post-clr latency", 32'(cyc), 32'd30);
    chk("post-clr class",   32'(oc[1]), 32'd2);
    chk("post-clr score",   32'(os[1]), 32'd95);
    tick();

    // Randomized traffic: data, gaps, back-pressure and occasional clr
    for (int n = 0; n < 2500; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = NI*IW'($urandom);
      out_ready = ($urandom_range(2) != 0);
      clr       = ($urandom_range(149) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pow2_mlp.md
SEQ_POW2_MLP -- requirements
Module: seq_pow2_mlp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The parameters SHALL be:
- N_IN, default 6: input features.
- IN_W, default 4: unsigned feature width.
- N_HID, default 3: hidden neurons.
- N_OUT, default 3: output classes, minimum 2.
- ACT_W, default 8: hidden activation width.
- ACC_W, default 16: signed accumulator width.
- W0, W1: packed 5-bit weight codes {zero, sign, shift[2:0]}.
- B0, B1: packed signed ACC_W biases.
REQ-003 The ports SHALL be:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- clr, in, 1: synchronous abort.
- in_valid, in, 1: feature vector valid.
- in_ready, out, 1: block accepts a vector.
- in_data, in, N_IN*IN_W: features, feature i at bits [i*IN_W +: IN_W].
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_class, out, max(1,clog2(N_OUT)): winning class index.
- out_score, out, ACC_W: winning class score.
- busy, out, 1: not in IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, L0, L1, ARGMAX and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; an accepted in_valid&in_ready SHALL register in_data and enter L0 on the next cycle.
REQ-006 Each weight term SHALL be 0 when zero=1, otherwise ±(x<<shift) zero-extended to ACC_W, negated when sign=1.
REQ-007 L0 SHALL perform one term per cycle, neuron-major, for N_HID*N_IN cycles, with acc = bias + term on each neuron's first term.
REQ-008 On a neuron's last term, the hidden activation SHALL be 0 if the sum is negative, 2^ACT_W-1 if the sum exceeds it, and the sum otherwise.
REQ-009 L1 SHALL take N_OUT*N_HID cycles, use the hidden activations as inputs, and apply ReLU without upper saturation.
REQ-010 Accumulation SHALL saturate to the signed ACC_W range and never wrap.
REQ-011 ARGMAX SHALL take N_OUT cycles, one score compare per cycle, replacing the running maximum only on strictly greater, so ties resolve to the lowest index.
REQ-012 out_valid SHALL assert in DONE exactly N_HID*N_IN + N_OUT*N_HID + N_OUT cycles after acceptance (30 with defaults).
REQ-013 out_class and out_score SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 out_valid&out_ready SHALL return the FSM to IDLE on the next cycle, and no new input SHALL be accepted in that same cycle.
REQ-015 clr=1 in any state SHALL force IDLE on the next cycle, deassert out_valid and discard partial results; clr takes priority over every handshake.
REQ-016 in_valid asserted outside IDLE SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE and set in_ready=1, out_valid=0, busy=0, out_class=0, out_score=0, and clear all accumulators and activations.
REQ-018 Reset asserted mid-computation SHALL abandon the computation, and no out_valid SHALL be produced for that vector.

Structure
REQ-019 Package mlp_pkg SHALL hold the weight-code typedef and field offsets, the FSM state enum, and the ACC_W saturating-add function.
REQ-020 A sub-module pow2_term SHALL implement the combinational code-to-signed-term generation of REQ-006.
REQ-021 The datapath SHALL contain exactly one adder-accumulator shared by L0 and L1.
REQ-022 Target implementation size SHALL be 120-400 lines.

Verification
REQ-023 The bench SHALL cover these scenarios, with config T1 = W0 all +1 shift0, W1 identity (+1 on diagonal, zero elsewhere), B0=B1=0:
- T1, in_data all 15: out_valid at cycle 30, out_class=0 (three-way tie on 90), out_score=90.
- T1 with B1={0,0,5}, in_data all 15: out_class=2, out_score=95.
- W0 all +shift3, W1 identity, in_data all 15: hidden saturates to 255, out_score=255.
- W0 all -1 (sign=1, shift0): hidden=0, all scores 0, out_class=0, out_score=0.
- T1 with out_ready low for 5 cycles after out_valid: out_valid, out_class and out_score held; in_ready=0; a simultaneous in_valid pulse is ignored.
- rst_n low at cycle 10, or clr at cycle 20: no out_valid; in_ready=1 the cycle after release; the next vector completes correctly.
